// File: rtl/pixel_coord_gen_if.sv
// Beat stream leaving pixel_coord_gen: NUM_LANES horizontally adjacent pixels per beat.
// A beat transfers on a rising edge where out_valid && out_ready; while out_valid && !out_ready the payload is held stable.
interface pixel_coord_gen_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_LANES   = 4
);
    logic                                  out_valid;
    logic                                  out_ready;
    logic [10:0]                           out_x;
    logic [10:0]                           out_y;
    logic signed [NUM_LANES*WORD_LENGTH-1:0] out_re;
    logic signed [WORD_LENGTH-1:0]         out_im;
    logic                                  out_eol;
    logic                                  out_eof;

    modport master (
        output out_valid, out_x, out_y, out_re, out_im, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, out_re, out_im, out_eol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/pixel_coord_gen.sv
// Raster generator of complex-plane pixel coordinates, NUM_LANES pixels per beat.
// Optional macro PIXEL_COORD_GEN_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module pixel_coord_gen #(
    parameter int WORD_LENGTH   = 32,
    parameter int FRAC          = 28,
    parameter int SCREEN_WIDTH  = 960,
    parameter int SCREEN_HEIGHT = 720,
    parameter int NUM_LANES     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [4:0]                    zoom,
    input  logic signed [WORD_LENGTH-1:0] real_center,
    input  logic signed [WORD_LENGTH-1:0] imag_center,
    output logic                          busy,
    output logic                          frame_done,
`ifdef PIXEL_COORD_GEN_FRAME_CNT_EN
    output logic [15:0]                   frame_count,
`endif
    output logic [1:0]                    state_dbg,
    pixel_coord_gen_if.master             ob
);
    localparam int WL = WORD_LENGTH;
    localparam longint SPAN_RE_L = longint'(3) << FRAC;
    localparam longint SPAN_IM_L = longint'(2) << FRAC;
    localparam logic signed [WL-1:0] SPAN_RE      = WL'(SPAN_RE_L);
    localparam logic signed [WL-1:0] SPAN_IM      = WL'(SPAN_IM_L);
    localparam logic signed [WL-1:0] BASE_STEP_RE = WL'(SPAN_RE_L / SCREEN_WIDTH);
    localparam logic signed [WL-1:0] BASE_STEP_IM = WL'(SPAN_IM_L / SCREEN_HEIGHT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]                  state;
    logic [10:0]                 x_q, y_q;
    logic signed [WL-1:0]        im_q, step_im_q, stride_re_q;
    logic [NUM_LANES*WL-1:0]     re_q, row_re_q;
    logic                        done_q;

    logic signed [WL-1:0]        step_re_s, step_im_s, acc_s, stride_s, imag_max_s;
    logic [NUM_LANES*WL-1:0]     row_s;
    logic [5:0]                  half_shift;
    logic                        row_last, col_last, xfer;

    // Frame-start values from the sampled zoom/centre; lane offsets built by an adder chain.
    always_comb begin
        half_shift = {1'b0, zoom} + 6'd1;
        step_re_s  = BASE_STEP_RE >>> zoom;
        step_im_s  = BASE_STEP_IM >>> zoom;
        imag_max_s = imag_center + (SPAN_IM >>> half_shift);
        acc_s      = real_center - (SPAN_RE >>> half_shift);
        row_s      = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            row_s[k*WL +: WL] = acc_s;
            acc_s = acc_s + step_re_s;
        end
        stride_s = acc_s - row_s[WL-1:0];
    end

    assign col_last = (x_q == 11'(SCREEN_WIDTH - NUM_LANES));
    assign row_last = (y_q == 11'(SCREEN_HEIGHT - 1));
    assign xfer     = (state == S_RUN) && ob.out_ready;

    assign ob.out_valid = (state == S_RUN);
    assign ob.out_eol   = (state == S_RUN) && col_last;
    assign ob.out_eof   = (state == S_RUN) && col_last && row_last;
    assign ob.out_x     = x_q;
    assign ob.out_y     = y_q;
    assign ob.out_re    = re_q;
    assign ob.out_im    = im_q;
    assign busy         = (state != S_IDLE);
    assign frame_done   = done_q;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            im_q        <= '0;
            step_im_q   <= '0;
            stride_re_q <= '0;
            re_q        <= '0;
            row_re_q    <= '0;
            done_q      <= 1'b0;
`ifdef PIXEL_COORD_GEN_FRAME_CNT_EN
            frame_count <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) state <= S_SETUP;
                end
                S_SETUP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        state       <= S_RUN;
                        x_q         <= '0;
                        y_q         <= '0;
                        step_im_q   <= step_im_s;
                        stride_re_q <= stride_s;
                        row_re_q    <= row_s;
                        re_q        <= row_s;
                        im_q        <= imag_max_s;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (xfer) begin
                        if (col_last) begin
                            x_q  <= '0;
                            re_q <= row_re_q;
                            im_q <= im_q - step_im_q;
                            if (row_last) begin
                                state  <= S_IDLE;
                                done_q <= 1'b1;
`ifdef PIXEL_COORD_GEN_FRAME_CNT_EN
                                frame_count <= frame_count + 16'd1;
`endif
                            end else begin
                                y_q <= y_q + 11'd1;
                            end
                        end else begin
                            x_q <= x_q + 11'(NUM_LANES);
                            for (int k = 0; k < NUM_LANES; k++)
                                re_q[k*WL +: WL] <= re_q[k*WL +: WL] + stride_re_q;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pixel_coord_gen.md
PIXEL_COORD_GEN -- requirements
Module: pixel_coord_gen

Interface
REQ-001 SHALL have parameters: WORD_LENGTH 32 (fixed-point width); FRAC 28 (fraction bits); SCREEN_WIDTH 960; SCREEN_HEIGHT 720; NUM_LANES 4 (pixels per beat, SHALL divide SCREEN_WIDTH).
REQ-002 Derived elaboration-time constants: BASE_STEP_RE = (3<<FRAC)/SCREEN_WIDTH and BASE_STEP_IM = (2<<FRAC)/SCREEN_HEIGHT, both truncated integers.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to generate one frame.
REQ-006 abort  in  1  flush the current frame.
REQ-007 zoom  in  5  zoom shift, sampled at frame start.
REQ-008 real_center, imag_center  in  WORD_LENGTH each  signed centre, sampled at frame start.
REQ-009 out_valid  out  1; out_ready  in  1  output handshake; a beat transfers when both are high.
REQ-010 out_x, out_y  out  11 each  pixel coordinate of lane 0.
REQ-011 out_re  out  NUM_LANES*WORD_LENGTH  lane k occupies bits [k*WL +: WL], signed.
REQ-012 out_im  out  WORD_LENGTH  signed imaginary part shared by all lanes.
REQ-013 out_eol, out_eof  out  1 each  last beat of the row and of the frame.
REQ-014 busy  out  1  high in every state except IDLE; frame_done  out  1  single-cycle pulse.

Function
REQ-015 FSM states SHALL be IDLE, SETUP and RUN.
REQ-016 Transitions: IDLE->SETUP on start; SETUP->RUN unconditionally; RUN->IDLE on the eof handshake or on abort. start SHALL be ignored outside IDLE.
REQ-017 In SETUP, latch step_re = BASE_STEP_RE>>>zoom and step_im = BASE_STEP_IM>>>zoom.
REQ-018 In SETUP, latch real_min = real_center - ((3<<FRAC)>>>(zoom+1)) and imag_max = imag_center + ((2<<FRAC)>>>(zoom+1)).
REQ-019 All arithmetic SHALL be WORD_LENGTH-bit two's complement and SHALL wrap modulo 2^WL, with no saturation.
REQ-020 Raster order: x advances by NUM_LANES from 0 to SCREEN_WIDTH-NUM_LANES; y advances from 0 to SCREEN_HEIGHT-1.
REQ-021 Per-beat values: lane k re = real_min + (x+k)*step_re; im = imag_max - y*step_im.
REQ-022 Values SHALL be produced by incremental accumulation without per-pixel multipliers, and SHALL be bit-exact to REQ-021.
REQ-023 out_valid SHALL first rise 2 cycles after start is sampled in IDLE, and then stay high every cycle in RUN.
REQ-024 While out_valid && !out_ready, all out_* SHALL hold stable. Nothing SHALL advance without a handshake.
REQ-025 out_eol SHALL be high when x = SCREEN_WIDTH-NUM_LANES. out_eof SHALL be high when out_eol is high and y = SCREEN_HEIGHT-1.
REQ-026 frame_done SHALL pulse one cycle after the eof handshake. On that cycle out_valid = 0 and busy = 0.
REQ-027 start SHALL be sampled in the same cycle frame_done pulses, because the FSM is already in IDLE.
REQ-028 abort SHALL take priority over start and over a handshake.
REQ-029 Next cycle after abort: state IDLE, out_valid = 0, and frame_done not asserted.
REQ-030 Changes to zoom or centre during a frame SHALL NOT affect that frame.

Reset
REQ-031 On rst: state IDLE; out_valid, busy, frame_done, out_eol and out_eof = 0; out_x, out_y, out_re and out_im = 0; all internal accumulators = 0.
REQ-032 rst SHALL override start and abort. rst mid-frame SHALL discard the frame with no frame_done pulse.

Configuration
REQ-033 With macro PIXEL_COORD_GEN_FRAME_CNT_EN defined: add output frame_count (16 bits).
REQ-034 frame_count SHALL reset to 0 and increment on each frame_done, wrapping 65535->0. Aborted frames SHALL NOT be counted.
REQ-035 Without the macro: the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (SCREEN_WIDTH=8, SCREEN_HEIGHT=4, NUM_LANES=4, FRAC=28, WL=32)
REQ-036 Basic frame: zoom=0, centres 0, out_ready=1, start pulse.
- out_valid rises at cycle +2.
- Beat 0 lanes = -402653184, -301989888, -201326592, -100663296; out_im = 268435456.
- Beat 1 lanes = 0, 100663296, 201326592, 301989888 with eol=1.
- Beats per frame = 8.
- Row out_im values = 268435456, 134217728, 0, -134217728.
- Final beat has eof=1; frame_done pulses the next cycle.
REQ-037 Backpressure: drop out_ready randomly at 50% -> the sequence is identical to REQ-036 and outputs stay stable on every stalled cycle.
REQ-038 Zoom: zoom=2, real_center=0x10000000 -> step_re = 25165824, lane0 beat0 = 167772160; a zoom change mid-frame has no effect.
REQ-039 Abort: abort on beat 3 together with out_ready=1 and start=1 -> next cycle out_valid=0, busy=0, no frame_done, frame_count unchanged.
REQ-040 Back-to-back frames: start coincident with frame_done -> second frame begins, frame_count = 2 after it completes. Reset mid-frame -> all outputs 0 next cycle.
